// File: rtl/bsg_manycore_pkg.sv
// Shared manycore definitions used by the SPMD loader and the loader injector.
// Holds the packet op encodings and the packet layout helpers. Op values
// are referenced only through these names so that the encodings can change
// without touching the loader or the injector.
//
// Packet layout (LSB first):
//   op(2) | addr(addr_width) | data(data_width) | src_x | src_y | dst_x | dst_y
package bsg_manycore_pkg;

  localparam int op_width_gp = 2;
  localparam int op_lsb_gp   = 0;

  // Remote store to a tile or DRAM word.
  localparam logic [op_width_gp-1:0] op_remote_store_gp = 2'b01;
  // Configuration / unfreeze write; it must not overtake outstanding stores.
  localparam logic [op_width_gp-1:0] op_config_gp       = 2'b10;

  // Total packet width for a given field sizing. The source and destination
  // coordinates each carry an x and a y field.
  function automatic int packet_width(input int addr_width,
                                      input int data_width,
                                      input int x_cord_width,
                                      input int y_cord_width);
    return op_width_gp + addr_width + data_width + 2 * (x_cord_width + y_cord_width);
  endfunction

endpackage

// File: rtl/bsg_manycore_credit_counter.sv
// Saturating up/down credit counter. Resets to max_val_p (all credits
// available). dec_i consumes one credit, inc_i returns one; both together
// cancel out. A return while already at max leaves the count at max and
// raises overflow_o for that cycle; the caller decides whether to latch it.
//
// Ports:
//   clk_i, reset_i  clock and synchronous active-high reset
//   dec_i           one credit consumed this cycle
//   inc_i           one credit returned this cycle
//   count_o         credits currently available (registered)
//   overflow_o      return arrived with the counter already full (combinational)
module bsg_manycore_credit_counter #(
  parameter int max_val_p = 16
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           dec_i,
  input  logic                           inc_i,
  output logic [$clog2(max_val_p+1)-1:0] count_o,
  output logic                           overflow_o
);

  localparam int width_lp = $clog2(max_val_p+1);
  localparam logic [width_lp-1:0] max_lp = width_lp'(max_val_p);
  localparam logic [width_lp-1:0] one_lp = width_lp'(1);

  logic [width_lp-1:0] count_reg, count_next;

  always_comb begin
    count_next = count_reg;
    overflow_o = 1'b0;
    if (dec_i && !inc_i) begin
      // Upstream gating keeps dec_i low at zero; the guard only stops a wrap.
      if (count_reg != '0) count_next = count_reg - one_lp;
    end else if (inc_i && !dec_i) begin
      if (count_reg == max_lp) overflow_o = 1'b1;
      else                     count_next = count_reg + one_lp;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) count_reg <= max_lp;
    else         count_reg <= count_next;
  end

  assign count_o = count_reg;

endmodule

// File: rtl/bsg_manycore_loader_injector.sv
// Sits between the SPMD loader packet output and the manycore mesh link.
// Buffers loader packets in a two-entry FIFO and meters injection against a
// remote-store credit budget. A config/unfreeze packet at the head is held
// until every previously sent packet has been acknowledged (credits back at
// max), so the tiles never unfreeze before their program image has landed.
//
// Ports:
//   clk_i, reset_i     clock and synchronous active-high reset
//   packet_i/v_i       packet from the loader, valid
//   ready_o            buffer has room (depends on registered state only)
//   packet_o/v_o       head packet to the mesh link, valid
//   ready_i            link accepts packet_o
//   credit_return_v_i  one store acknowledgement this cycle
//   out_credits_o      credits currently available
//   drained_o          buffer empty and all credits returned
//   error_o            sticky: credit returned while already at max
module bsg_manycore_loader_injector
  import bsg_manycore_pkg::*;
#(
  parameter int addr_width_p      = 30,
  parameter int data_width_p      = 32,
  // Coordinate widths have no meaningful default and are set per fabric.
  parameter int x_cord_width_p    = 4,
  parameter int y_cord_width_p    = 4,
  parameter int max_out_credits_p = 16,
  localparam int credit_width_lp  = $clog2(max_out_credits_p+1),
  localparam int packet_width_lp  = packet_width(addr_width_p, data_width_p,
                                                 x_cord_width_p, y_cord_width_p)
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [packet_width_lp-1:0] packet_i,
  input  logic                       v_i,
  output logic                       ready_o,
  output logic [packet_width_lp-1:0] packet_o,
  output logic                       v_o,
  input  logic                       ready_i,
  input  logic                       credit_return_v_i,
  output logic [credit_width_lp-1:0] out_credits_o,
  output logic                       drained_o,
  output logic                       error_o
);

  localparam logic [credit_width_lp-1:0] max_credits_lp = credit_width_lp'(max_out_credits_p);

  // Two-entry FIFO storage; payload is not reset, only the pointers/count.
  logic [packet_width_lp-1:0] mem_reg [2];
  logic       wr_ptr_reg, rd_ptr_reg;
  logic [1:0] count_reg, count_next;
  logic       error_reg;

  logic enq, deq, empty, head_is_fence, overflow;
  logic [packet_width_lp-1:0] head;

  assign empty   = (count_reg == 2'd0);
  assign ready_o = (count_reg != 2'd2);
  assign head    = mem_reg[rd_ptr_reg];

  assign head_is_fence = (head[op_lsb_gp +: op_width_gp] == op_config_gp);

  // Fence packets also spend a credit, so they need one available as well as
  // an otherwise idle credit pool.
  assign v_o = !empty && (out_credits_o != '0)
               && (!head_is_fence || out_credits_o == max_credits_lp);

  assign enq = v_i && ready_o;
  assign deq = v_o && ready_i;

  always_comb begin
    count_next = count_reg;
    case ({enq, deq})
      2'b10:   count_next = count_reg + 2'd1;
      2'b01:   count_next = count_reg - 2'd1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
      error_reg  <= 1'b0;
    end else begin
      if (enq) wr_ptr_reg <= ~wr_ptr_reg;
      if (deq) rd_ptr_reg <= ~rd_ptr_reg;
      count_reg <= count_next;
      if (overflow) error_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) mem_reg[wr_ptr_reg] <= packet_i;
  end

  bsg_manycore_credit_counter #(
    .max_val_p(max_out_credits_p)
  ) credit_counter (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .dec_i     (deq),
    .inc_i     (credit_return_v_i),
    .count_o   (out_credits_o),
    .overflow_o(overflow)
  );

  assign packet_o  = head;
  assign drained_o = empty && (out_credits_o == max_credits_lp);
  assign error_o   = error_reg;

endmodule

// File: tb/tb_bsg_manycore_loader_injector.sv
// Directed scoreboard bench for bsg_manycore_loader_injector. Accepted input
// packets are queued as expected outputs; a monitor on the falling edge pops
// and compares on every send. Inputs change 2 time units after the rising edge.
module tb_bsg_manycore_loader_injector;
  import bsg_manycore_pkg::*;

  localparam int PW = packet_width(30, 32, 4, 4);
  localparam int CW = $clog2(16+1);

  logic          clk_i = 1'b0;
  logic          reset_i = 1'b1;
  logic [PW-1:0] packet_i = '0;
  logic          v_i = 1'b0;
  logic          ready_o;
  logic [PW-1:0] packet_o;
  logic          v_o;
  logic          ready_i = 1'b0;
  logic          credit_return_v_i = 1'b0;
  logic [CW-1:0] out_credits_o;
  logic          drained_o;
  logic          error_o;

  bsg_manycore_loader_injector #(
    .addr_width_p(30), .data_width_p(32), .x_cord_width_p(4),
    .y_cord_width_p(4), .max_out_credits_p(16)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .packet_i(packet_i), .v_i(v_i),
    .ready_o(ready_o), .packet_o(packet_o), .v_o(v_o), .ready_i(ready_i),
    .credit_return_v_i(credit_return_v_i), .out_credits_o(out_credits_o),
    .drained_o(drained_o), .error_o(error_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;
  int sent_total = 0;
  int returned   = 0;
  int n_acc      = 0;
  int n_target   = 0;
  int fence_idx  = -1;
  int cyc        = 0;
  logic [PW-1:0] exp_q [$];
  int send_cyc [$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk_i) cyc++;

  // Monitor: every send is compared against the oldest accepted packet.
  always @(negedge clk_i) begin
    if (!reset_i && v_o && ready_i) begin
      sent_total++;
      send_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_send: got %0h expected no packet", packet_o);
      end else begin
        check("packet_o", packet_o, exp_q.pop_front());
      end
    end
  end

  function automatic logic [PW-1:0] mk(input int idx);
    logic [PW-1:0] p;
    p = PW'({16'hC0DE, 32'h1000_0000 + 32'(idx), 30'(idx * 5 + 1), 2'b00});
    p[1:0] = (idx == fence_idx) ? op_config_gp : op_remote_store_gp;
    return p;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  // One cycle of stimulus: feed the next packet if any remain, drive ready_i
  // and an optional credit return. ready_o is already settled for the edge.
  task automatic cycle(input bit rdy, input bit ret);
    ready_i = rdy;
    if (n_acc < n_target) begin
      v_i = 1'b1;
      packet_i = mk(n_acc);
    end else begin
      v_i = 1'b0;
    end
    if (v_i && ready_o) begin
      exp_q.push_back(packet_i);
      n_acc++;
    end
    credit_return_v_i = ret;
    if (ret) returned++;
    tick();
    v_i = 1'b0;
    credit_return_v_i = 1'b0;
  endtask

  // Feed remaining packets and return every outstanding credit until idle.
  task automatic drain(input string name);
    int k;
    k = 0;
    while (!(n_acc == n_target && drained_o && sent_total == returned) && k < 200) begin
      cycle(1'b1, sent_total > returned);
      k++;
    end
    check({name, "_drained"}, drained_o, 1'b1);
    check({name, "_credits"}, out_credits_o, 16);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tick(); tick();
    reset_i = 1'b0;
    tick();

    // Reset state
    check("rst_v_o", v_o, 0);
    check("rst_ready_o", ready_o, 1);
    check("rst_credits", out_credits_o, 16);
    check("rst_drained", drained_o, 1);
    check("rst_error", error_o, 0);

    // 20 back-to-back stores with no returns: 16 go out, 2 buffered, stall
    n_target = 20;
    for (int i = 0; i < 30; i++) cycle(1'b1, 1'b0);
    check("burst_sent", sent_total, 16);
    if (send_cyc.size() >= 16) check("burst_consecutive", send_cyc[15] - send_cyc[0], 15);
    else check("burst_consecutive", send_cyc.size(), 16);
    check("burst_v_o", v_o, 0);
    check("burst_credits", out_credits_o, 0);
    check("burst_ready_o", ready_o, 0);
    check("burst_accepted", n_acc, 18);
    cycle(1'b1, 1'b1);
    check("one_ret_credits", out_credits_o, 1);
    check("one_ret_v_o", v_o, 1);
    cycle(1'b1, 1'b0);
    check("one_ret_sent", sent_total, 17);
    check("one_ret_credits0", out_credits_o, 0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0);
    check("one_ret_exactly_one", sent_total, 17);
    drain("burst");
    check("burst_total", sent_total, 20);

    // Fence: 3 stores then a config packet, returns held back 10+ cycles
    fence_idx = n_target + 3;
    n_target  = n_target + 4;
    for (int i = 0; i < 14; i++) cycle(1'b1, 1'b0);
    check("fence_held_v_o", v_o, 0);
    check("fence_held_credits", out_credits_o, 13);
    check("fence_held_sent", sent_total, 23);
    cycle(1'b1, 1'b1);
    check("fence_ret1_v_o", v_o, 0);
    check("fence_ret1_credits", out_credits_o, 14);
    cycle(1'b1, 1'b1);
    check("fence_ret2_v_o", v_o, 0);
    cycle(1'b1, 1'b1);
    check("fence_ret3_credits", out_credits_o, 16);
    check("fence_release_v_o", v_o, 1);
    cycle(1'b1, 1'b0);
    check("fence_sent", sent_total, 24);
    check("fence_credit_used", out_credits_o, 15);
    drain("fence");

    // Simultaneous send and return at 7 credits
    n_target = n_target + 9;
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0);
    n_target = n_target + 2;
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0);
    check("simul_pre_credits", out_credits_o, 7);
    check("simul_pre_v_o", v_o, 1);
    cycle(1'b1, 1'b1);
    check("simul_credits", out_credits_o, 7);
    check("simul_sent", sent_total, 34);
    drain("simul");

    // Spurious return while full
    credit_return_v_i = 1'b1;
    tick();
    credit_return_v_i = 1'b0;
    check("ovf_error", error_o, 1);
    check("ovf_credits", out_credits_o, 16);
    for (int i = 0; i < 3; i++) tick();
    check("ovf_error_sticky", error_o, 1);
    check("ovf_drained", drained_o, 1);

    // Reset with 2 buffered and 5 outstanding
    n_target = n_target + 5;
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0);
    n_target = n_target + 2;
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0);
    check("prerst_credits", out_credits_o, 11);
    check("prerst_ready_o", ready_o, 0);
    reset_i = 1'b1;
    tick();
    check("midrst_v_o", v_o, 0);
    check("midrst_credits", out_credits_o, 16);
    check("midrst_drained", drained_o, 1);
    check("midrst_ready_o", ready_o, 1);
    check("midrst_error", error_o, 0);
    reset_i = 1'b0;
    exp_q.delete();
    returned = sent_total;
    n_acc = n_target;
    tick();

    check("final_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
